bus_rr_arbiter: RTL and testbench
=================================

// Module: bus_rr_arbiter
// PURPOSE
//  Parametrised successor to the datapath bus mux: NUM_SRC requesters, each with a data word and a request line.
//  A round-robin arbiter grants one owner at a time and drives a registered bus word with a valid flag.
//  Optional lock allows bursts, capped at MAX_BURST beats. Sits between the register file/special regs and all bus sinks.
// PARAMETERS
//  DATA_W     32  bus word width
//  NUM_SRC    24  number of requesting sources (>=2)
//  MAX_BURST  4   max consecutive beats for one locked owner (>=1)
//  IDX_W      $clog2(NUM_SRC)  grant index width (derived, not overridden)
// PORTS
//  clock      in   1                clock; all state updates on rising edge
//  reset      in   1                synchronous, active-high reset
//  src_data   in   NUM_SRC*DATA_W   packed source words; source i at [i*DATA_W +: DATA_W]
//  src_req    in   NUM_SRC          request per source
//  src_lock   in   NUM_SRC          owner keeps bus next beat if its req and lock are both high
//  grant      out  NUM_SRC          one-hot current owner, registered
//  grant_idx  out  IDX_W            binary index of owner; valid only when bus_valid=1
//  bus_out    out  DATA_W           registered bus word
//  bus_valid  out  1                bus_out carries a granted beat this cycle
//  busy       out  1                1 in OWN state
// BEHAVIOUR
//  Interface: one clock, clock; reset is synchronous and active-high.
//  Reset values: grant=0, grant_idx=0, bus_out=0, bus_valid=0, busy=0, state=IDLE, rr_ptr=0, beat_cnt=0.
//  Reset during a burst aborts it; the next cycle is IDLE with all outputs at reset values.
//  FSM states: IDLE, OWN.
//  IDLE
//   - If any src_req at edge t: pick the first requester at or after rr_ptr, wrapping modulo NUM_SRC.
//   - After edge t: grant/grant_idx set, bus_out = that source's word sampled at t, bus_valid=1, beat_cnt=1, state=OWN.
//   - Latency is one cycle, request to valid.
//   - No request: bus_out holds its last value, bus_valid=0.
//  OWN (owner o)
//   - Keep: src_req[o] && src_lock[o] && beat_cnt<MAX_BURST.
//     bus_out reloads src_data[o], bus_valid=1, beat_cnt++.
//   - Otherwise release. rr_ptr=(o+1) mod NUM_SRC, and re-arbitrate in the same cycle from the new pointer.
//   - Release with another requester: its grant and data appear after the same edge. No idle bubble (back-to-back).
//   - Release with no requester: state=IDLE, grant=0, bus_valid=0, bus_out holds.
//   - Owner may win again after release only if it is the sole requester.
//   - Lock high with req low counts as release. Lock on a non-owner is ignored.
//  beat_cnt saturates at MAX_BURST. A forced release at the cap behaves as a normal release.
//  rr_ptr wraps from NUM_SRC-1 to 0. Updated only on release, never in IDLE.
//  The grant vector is always zero- or one-hot. Multiple requests never merge data (no OR-bus).
// CONFIGURATION
//  BUS_RR_STATS_EN defined adds outputs stat_beats[31:0] and stat_contend[31:0].
//   - stat_beats: cycles with bus_valid=1.
//   - stat_contend: cycles with >=2 src_req bits high.
//   - Both are saturating and cleared by reset.
//  Undefined: the ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Package bus_pkg: DATA_W default, state enum {IDLE, OWN}, idx-to-onehot function.
//  Sub-module rr_pick: combinational. Inputs req vector and rr_ptr; outputs found flag, winner idx, one-hot.
//  Top holds the FSM, registers, data mux and optional stats.
// TESTING
//  1 Single request: req[5]=1, data=32'hA5A5_0005, one cycle -> next cycle grant=1<<5, grant_idx=5, bus_out=A5A5_0005, bus_valid=1; then IDLE, bus_out holds.
//  2 Round-robin: req[0], req[3] and req[23] held continuously, no lock -> owners 0,3,23,0,... on consecutive cycles, bus_valid continuously 1.
//  3 Burst cap: MAX_BURST=4, src 2 req+lock held, src 7 req -> four beats of src 2, then src 7 on the 5th cycle.
//  4 Reset mid-burst: reset at 2nd beat of a burst -> next cycle grant=0, bus_out=0, bus_valid=0, rr_ptr=0; first grant afterwards goes to lowest requester.
//  5 Wrap: owner 23 releases, req[0] and req[22] high -> grant_idx=0.
//  6 With BUS_RR_STATS_EN: 10 cycles, 3 contended, 8 valid -> stat_contend=3, stat_beats=8.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package bus_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned MAX_SRC    = 64;
  localparam int unsigned MAX_IDX_W  = 6;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  function automatic logic [MAX_SRC-1:0] idx_to_onehot(input logic [MAX_IDX_W-1:0] idx);
    logic [MAX_SRC-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping.
module rr_pick
  import bus_pkg::*;
#(
  parameter int unsigned NUM_SRC = 24,
  parameter int unsigned IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_found_c,
  output logic [IDX_W-1:0]   o_idx_c,
  output logic [NUM_SRC-1:0] o_onehot_c
);

  always_comb begin
    int unsigned w_cand;
    o_found_c = 1'b0;
    o_idx_c   = '0;
    w_cand    = 0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      w_cand = 32'(i_ptr) + i;
      if (w_cand >= NUM_SRC) w_cand = w_cand - NUM_SRC;
      if (!o_found_c && i_req[IDX_W'(w_cand)]) begin
        o_found_c = 1'b1;
        o_idx_c   = IDX_W'(w_cand);
      end
    end
  end

  assign o_onehot_c = o_found_c ? NUM_SRC'(idx_to_onehot(MAX_IDX_W'(o_idx_c))) : '0;

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with lockable bursts capped at MAX_BURST beats.
// Optional BUS_RR_STATS_EN adds saturating stat_beats / stat_contend counters.
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter  int unsigned DATA_W    = DEF_DATA_W,
  parameter  int unsigned NUM_SRC   = 24,
  parameter  int unsigned MAX_BURST = 4,
  localparam int unsigned IDX_W     = $clog2(NUM_SRC)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic [NUM_SRC-1:0]        src_lock,
  output logic [NUM_SRC-1:0]        grant,
  output logic [IDX_W-1:0]          grant_idx,
  output logic [DATA_W-1:0]         bus_out,
  output logic                      bus_valid,
  output logic                      busy
`ifdef BUS_RR_STATS_EN
  ,
  output logic [31:0]               stat_beats,
  output logic [31:0]               stat_contend
`endif
);

  localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

  state_e              r_state;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [IDX_W-1:0]    r_grant_idx;
  logic [BEAT_W-1:0]   r_beat_cnt;
  logic [NUM_SRC-1:0]  r_grant;
  logic [DATA_W-1:0]   r_bus_out;
  logic                r_bus_valid;
  logic                r_busy;

  logic [DATA_W-1:0]   w_words [NUM_SRC];
  logic [IDX_W-1:0]    w_next_ptr;
  logic [IDX_W-1:0]    w_pick_ptr;
  logic                w_keep;
  logic                w_found;
  logic [IDX_W-1:0]    w_pick_idx;
  logic [NUM_SRC-1:0]  w_pick_oh;

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      w_words[i] = src_data[i*DATA_W +: DATA_W];
    end
  end

  // On release the search restarts just past the outgoing owner in the same cycle.
  assign w_next_ptr = (r_grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : r_grant_idx + IDX_W'(1);
  assign w_pick_ptr = (r_state == OWN) ? w_next_ptr : r_rr_ptr;
  assign w_keep     = src_req[r_grant_idx] && src_lock[r_grant_idx] &&
                      (r_beat_cnt < BEAT_W'(MAX_BURST));

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req      (src_req),
    .i_ptr      (w_pick_ptr),
    .o_found_c  (w_found),
    .o_idx_c    (w_pick_idx),
    .o_onehot_c (w_pick_oh)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
      r_beat_cnt  <= '0;
      r_grant     <= '0;
      r_bus_out   <= '0;
      r_bus_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state     <= OWN;
            r_grant     <= w_pick_oh;
            r_grant_idx <= w_pick_idx;
            r_bus_out   <= w_words[w_pick_idx];
            r_bus_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_beat_cnt  <= BEAT_W'(1);
          end else begin
            r_bus_valid <= 1'b0;
          end
        end
        OWN: begin
          if (w_keep) begin
            r_bus_out   <= w_words[r_grant_idx];
            r_bus_valid <= 1'b1;
            r_beat_cnt  <= r_beat_cnt + BEAT_W'(1);
          end else begin
            r_rr_ptr <= w_next_ptr;
            if (w_found) begin
              r_grant     <= w_pick_oh;
              r_grant_idx <= w_pick_idx;
              r_bus_out   <= w_words[w_pick_idx];
              r_bus_valid <= 1'b1;
              r_beat_cnt  <= BEAT_W'(1);
            end else begin
              r_state     <= IDLE;
              r_grant     <= '0;
              r_grant_idx <= '0;
              r_bus_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_beat_cnt  <= '0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant     = r_grant;
  assign grant_idx = r_grant_idx;
  assign bus_out   = r_bus_out;
  assign bus_valid = r_bus_valid;
  assign busy      = r_busy;

`ifdef BUS_RR_STATS_EN
  logic [31:0] r_stat_beats;
  logic [31:0] r_stat_contend;
  logic        w_contend;

  // Two or more bits set: clearing the lowest set bit leaves something behind.
  assign w_contend = |(src_req & (src_req - NUM_SRC'(1)));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stat_beats   <= '0;
      r_stat_contend <= '0;
    end else begin
      if (r_bus_valid && (r_stat_beats != '1)) r_stat_beats <= r_stat_beats + 32'd1;
      if (w_contend && (r_stat_contend != '1)) r_stat_contend <= r_stat_contend + 32'd1;
    end
  end

  assign stat_beats   = r_stat_beats;
  assign stat_contend = r_stat_contend;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed self-checking bench for bus_rr_arbiter (24 sources, 32-bit words, burst cap 4).
module tb_bus_rr_arbiter;

  localparam int unsigned DW  = 32;
  localparam int unsigned NS  = 24;
  localparam int unsigned IW  = 5;

  logic              clock;
  logic              reset;
  logic [NS*DW-1:0]  src_data;
  logic [NS-1:0]     src_req;
  logic [NS-1:0]     src_lock;
  logic [NS-1:0]     grant;
  logic [IW-1:0]     grant_idx;
  logic [DW-1:0]     bus_out;
  logic              bus_valid;
  logic              busy;
`ifdef BUS_RR_STATS_EN
  logic [31:0]       stat_beats;
  logic [31:0]       stat_contend;
`endif

  logic [DW-1:0]     word [NS];
  int                n_tests;
  int                n_fail;

  bus_rr_arbiter #(
    .DATA_W    (DW),
    .NUM_SRC   (NS),
    .MAX_BURST (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .src_data  (src_data),
    .src_req   (src_req),
    .src_lock  (src_lock),
    .grant     (grant),
    .grant_idx (grant_idx),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .busy      (busy)
`ifdef BUS_RR_STATS_EN
    ,
    .stat_beats   (stat_beats),
    .stat_contend (stat_contend)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = word[i];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    src_req  = '0;
    src_lock = '0;
    step();
    reset = 1'b0;
  endtask

  int exp_rr [6] = '{0, 3, 23, 0, 3, 23};

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b1;
    src_req  = '0;
    src_lock = '0;
    for (int i = 0; i < NS; i++) word[i] = 32'hA5A5_0000 | 32'(i);
    step();
    step();
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_idx", 64'(grant_idx), 64'd0);
    check("rst_bus", 64'(bus_out), 64'd0);
    check("rst_valid", 64'(bus_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;

    // Single request, then lock-without-req releases to IDLE with data held
    src_req[5]  = 1'b1;
    src_lock[5] = 1'b1;
    step();
    check("single_grant", 64'(grant), 64'h20);
    check("single_idx", 64'(grant_idx), 64'd5);
    check("single_bus", 64'(bus_out), 64'hA5A5_0005);
    check("single_valid", 64'(bus_valid), 64'd1);
    check("single_busy", 64'(busy), 64'd1);
    src_req = '0;
    step();
    check("idle_grant", 64'(grant), 64'd0);
    check("idle_valid", 64'(bus_valid), 64'd0);
    check("idle_bus_hold", 64'(bus_out), 64'hA5A5_0005);
    check("idle_busy", 64'(busy), 64'd0);

    // Round-robin among 0, 3, 23 with no lock
    do_reset();
    src_req[0]  = 1'b1;
    src_req[3]  = 1'b1;
    src_req[23] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("rr_idx", 64'(grant_idx), 64'(exp_rr[k]));
      check("rr_valid", 64'(bus_valid), 64'd1);
      check("rr_bus", 64'(bus_out), 64'(32'hA5A5_0000 | 32'(exp_rr[k])));
    end

    // Wrap: owner 23 releases with 0 and 22 requesting
    do_reset();
    src_req[23] = 1'b1;
    step();
    check("wrap_own23", 64'(grant_idx), 64'd23);
    src_req     = '0;
    src_req[0]  = 1'b1;
    src_req[22] = 1'b1;
    step();
    check("wrap_idx", 64'(grant_idx), 64'd0);
    check("wrap_grant", 64'(grant), 64'h1);

    // Burst cap: src 2 locked, src 7 waiting; data reloads each beat
    do_reset();
    src_req[2]  = 1'b1;
    src_lock[2] = 1'b1;
    src_req[7]  = 1'b1;
    step();
    check("burst_b1", 64'(grant_idx), 64'd2);
    step();
    check("burst_b2", 64'(grant_idx), 64'd2);
    word[2] = 32'hDEAD_0002;
    step();
    check("burst_b3", 64'(grant_idx), 64'd2);
    check("burst_reload", 64'(bus_out), 64'hDEAD_0002);
    step();
    check("burst_b4", 64'(grant_idx), 64'd2);
    step();
    check("burst_cap_idx", 64'(grant_idx), 64'd7);
    check("burst_cap_bus", 64'(bus_out), 64'hA5A5_0007);
    check("burst_cap_valid", 64'(bus_valid), 64'd1);

    // Reset in the middle of a burst
    do_reset();
    src_req[2]  = 1'b1;
    src_lock[2] = 1'b1;
    src_req[9]  = 1'b1;
    step();
    step();
    check("mid_b2", 64'(grant_idx), 64'd2);
    reset = 1'b1;
    step();
    check("mid_rst_grant", 64'(grant), 64'd0);
    check("mid_rst_bus", 64'(bus_out), 64'd0);
    check("mid_rst_valid", 64'(bus_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    step();
    check("mid_after_idx", 64'(grant_idx), 64'd2);

`ifdef BUS_RR_STATS_EN
    // 3 contended cycles, bus valid before 8 of the 10 edges
    do_reset();
    check("stat_rst_beats", 64'(stat_beats), 64'd0);
    check("stat_rst_contend", 64'(stat_contend), 64'd0);
    for (int c = 1; c <= 10; c++) begin
      src_req    = '0;
      src_req[1] = (c <= 8);
      src_req[4] = (c <= 3);
      step();
    end
    check("stat_beats", 64'(stat_beats), 64'd8);
    check("stat_contend", 64'(stat_contend), 64'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
